// File: rtl/outport_credit.sv
// Output-port stage: registers the crossbar output onto the link and keeps
// one saturating credit counter per virtual channel.

`ifndef DATAW
`define DATAW 7
`endif
`ifndef VCHW
`define VCHW 0
`endif

module outport_credit #(
  parameter int NVC         = 2,
  parameter int CREDIT_INIT = 4,
  parameter int CNTW        = 4
) (
  input  logic                  clk,
  input  logic                  rst_,
  input  logic [`DATAW:0]       idata,
  input  logic                  ivalid,
  input  logic [`VCHW:0]        ivch,
  output logic [`DATAW:0]       odata,
  output logic                  ovalid,
  output logic [`VCHW:0]        ovch,
  input  logic                  icredit,
  input  logic [`VCHW:0]        icredit_vch,
  output logic [NVC-1:0]        ordy,
  output logic [NVC*CNTW-1:0]   ocnt,
  output logic [1:0]            err
);

  localparam int VW = `VCHW + 1;
  localparam logic signed [CNTW:0] INIT_S = (CNTW+1)'(CREDIT_INIT);

  logic [CNTW-1:0]        cnt      [NVC];
  logic [CNTW-1:0]        cnt_next [NVC];
  logic signed [CNTW:0]   sum      [NVC];
  logic signed [CNTW:0]   dec_s    [NVC];
  logic signed [CNTW:0]   inc_s    [NVC];
  logic [NVC-1:0]         under;
  logic [NVC-1:0]         over;

  // Per-VC next credit count: signed sum, clamped to 0..CREDIT_INIT with error flags
  always_comb begin
    under = '0;
    over  = '0;
    for (int v = 0; v < NVC; v++) begin
      dec_s[v]    = '0;
      inc_s[v]    = '0;
      dec_s[v][0] = ivalid && (ivch == VW'(v));
      inc_s[v][0] = icredit && (icredit_vch == VW'(v));
      sum[v]      = $signed({1'b0, cnt[v]}) - dec_s[v] + inc_s[v];
      cnt_next[v] = sum[v][CNTW-1:0];
      if (sum[v] < 0) begin
        cnt_next[v] = '0;
        under[v]    = 1'b1;
      end else if (sum[v] > INIT_S) begin
        cnt_next[v] = CNTW'(CREDIT_INIT);
        over[v]     = 1'b1;
      end
    end
  end

  // Link register, credit counters and sticky error flags
  always_ff @(posedge clk) begin
    if (rst_) begin
      odata  <= '0;
      ovch   <= '0;
      ovalid <= 1'b0;
      err    <= '0;
      for (int v = 0; v < NVC; v++) cnt[v] <= CNTW'(CREDIT_INIT);
    end else begin
      ovalid <= ivalid;
      if (ivalid) begin
        odata <= idata;
        ovch  <= ivch;
      end
      for (int v = 0; v < NVC; v++) cnt[v] <= cnt_next[v];
      if (|under) err[0] <= 1'b1;
      if (|over)  err[1] <= 1'b1;
    end
  end

  // Ready flags and debug counter view decoded from the counter registers
  always_comb begin
    ordy = '0;
    ocnt = '0;
    for (int v = 0; v < NVC; v++) begin
      ordy[v]               = (cnt[v] != '0);
      ocnt[v*CNTW +: CNTW]  = cnt[v];
    end
  end

endmodule

// File: tb/tb_outport_credit.sv
// Scoreboard bench for outport_credit: stimulus pushes expectations,
// a negedge monitor pops and compares them.

`ifndef DATAW
`define DATAW 7
`endif
`ifndef VCHW
`define VCHW 0
`endif

module tb_outport_credit;

  logic              clk = 1'b0;
  logic              rst_ = 1'b0;
  logic [`DATAW:0]   idata = '0;
  logic              ivalid = 1'b0;
  logic [`VCHW:0]    ivch = '0;
  logic [`DATAW:0]   odata;
  logic              ovalid;
  logic [`VCHW:0]    ovch;
  logic              icredit = 1'b0;
  logic [`VCHW:0]    icredit_vch = '0;
  logic [1:0]        ordy;
  logic [7:0]        ocnt;
  logic [1:0]        err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       valid;
    logic [3:0] c0;
    logic [3:0] c1;
    logic [1:0] err;
    logic       chk_zero;
  } exp_t;

  exp_t             sq[$];
  logic [8:0]       dq[$];

  outport_credit #(.NVC(2), .CREDIT_INIT(4), .CNTW(4)) dut (
    .clk(clk), .rst_(rst_), .idata(idata), .ivalid(ivalid), .ivch(ivch),
    .odata(odata), .ovalid(ovalid), .ovch(ovch), .icredit(icredit),
    .icredit_vch(icredit_vch), .ordy(ordy), .ocnt(ocnt), .err(err)
  );

  always #5 clk = ~clk;

  // One cycle of stimulus; expectations for the state after this edge are queued
  task automatic step(input logic r, input logic iv, input logic vc,
                      input logic [7:0] d, input logic cr, input logic cvc,
                      input logic [3:0] c0, input logic [3:0] c1,
                      input logic [1:0] e);
    exp_t x;
    rst_        = r;
    ivalid      = iv;
    ivch        = vc;
    idata       = d;
    icredit     = cr;
    icredit_vch = cvc;
    @(posedge clk);
    x.valid    = iv && !r;
    x.c0       = c0;
    x.c1       = c1;
    x.err      = e;
    x.chk_zero = r;
    sq.push_back(x);
    if (iv && !r) dq.push_back({vc, d});
    #1;
  endtask

  // Monitor: compare link data on ovalid and state against queued expectations
  initial begin
    exp_t x;
    logic [8:0] dexp;
    forever begin
      @(negedge clk);
      if (sq.size() > 0) begin
        x = sq.pop_front();
        checks++;
        if (ovalid !== x.valid) begin
          errors++;
          $display("[TB] FAIL ovalid got %b want %b", ovalid, x.valid);
        end
        checks++;
        if (ocnt !== {x.c1, x.c0}) begin
          errors++;
          $display("[TB] FAIL ocnt got %h want %h", ocnt, {x.c1, x.c0});
        end
        checks++;
        if (ordy !== {x.c1 != 0, x.c0 != 0}) begin
          errors++;
          $display("[TB] FAIL ordy got %b want %b", ordy, {x.c1 != 0, x.c0 != 0});
        end
        checks++;
        if (err !== x.err) begin
          errors++;
          $display("[TB] FAIL err got %b want %b", err, x.err);
        end
        if (x.chk_zero) begin
          checks++;
          if ({ovch, odata} !== 9'h000) begin
            errors++;
            $display("[TB] FAIL reset_link got %h want 000", {ovch, odata});
          end
        end
      end
      if (ovalid === 1'b1) begin
        checks++;
        if (dq.size() == 0) begin
          errors++;
          $display("[TB] FAIL flit got %h want none", {ovch, odata});
        end else begin
          dexp = dq.pop_front();
          if ({ovch, odata} !== dexp) begin
            errors++;
            $display("[TB] FAIL flit got %h want %h", {ovch, odata}, dexp);
          end
        end
      end
    end
  end

  // Directed vectors with hand-computed expected counts and error flags
  initial begin
    #1;
    // reset and idle
    step(1, 0, 0, 8'h00, 0, 0, 4, 4, 2'b00);
    step(0, 0, 0, 8'h00, 0, 0, 4, 4, 2'b00);
    // four back-to-back flits on VC0
    step(0, 1, 0, 8'h11, 0, 0, 3, 4, 2'b00);
    step(0, 1, 0, 8'h12, 0, 0, 2, 4, 2'b00);
    step(0, 1, 0, 8'h13, 0, 0, 1, 4, 2'b00);
    step(0, 1, 0, 8'h14, 0, 0, 0, 4, 2'b00);
    // simultaneous flit and credit at zero, then underflow
    step(0, 1, 0, 8'h21, 1, 0, 0, 4, 2'b00);
    step(0, 1, 0, 8'h22, 0, 0, 0, 4, 2'b01);
    // overflow on VC1, twice (sticky)
    step(0, 0, 0, 8'h00, 1, 1, 0, 4, 2'b11);
    step(0, 0, 0, 8'h00, 1, 1, 0, 4, 2'b11);
    // bring to cnt0=2, cnt1=3, then cross-VC flit+credit
    step(0, 0, 0, 8'h00, 1, 0, 1, 4, 2'b11);
    step(0, 0, 0, 8'h00, 1, 0, 2, 4, 2'b11);
    step(0, 1, 1, 8'h31, 0, 0, 2, 3, 2'b11);
    step(0, 1, 1, 8'h32, 1, 0, 3, 2, 2'b11);
    // VC0 stream down to cnt0=1, reset mid-stream, then resume
    step(0, 1, 0, 8'h41, 0, 0, 2, 2, 2'b11);
    step(0, 1, 0, 8'h42, 0, 0, 1, 2, 2'b11);
    step(1, 1, 0, 8'h43, 1, 1, 4, 4, 2'b00);
    step(0, 1, 0, 8'h44, 0, 0, 3, 4, 2'b00);
    step(0, 1, 0, 8'h45, 0, 0, 2, 4, 2'b00);
    step(0, 0, 0, 8'h00, 0, 0, 2, 4, 2'b00);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (dq.size() != 0 || sq.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain got %0d/%0d pending want 0/0", dq.size(), sq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/outport_credit.md
# outport_credit

Output-port stage placed directly downstream of one crossbar output (odata_N / ovalid_N / ovch_N). It registers the switched flit onto the inter-router link and keeps one credit counter per virtual channel, tracking free slots in the downstream router's input buffers. Per-VC ready flags go back to the switch/VC allocators so that requests are only raised for VCs with credit. One instance is used per router output port, five per router.

## Interface
Parameters:
- NVC, default 2: number of virtual channels; must equal 2^(`VCHW+1).
- CREDIT_INIT, default 4: downstream buffer depth per VC, in flits; range 1..15.
- CNTW, default 4: credit counter width; CREDIT_INIT must be ≤ 2^CNTW−1.

Ports:
- clk  in  1  router clock; all state updates on the rising edge.
- rst_  in  1  reset, synchronous, active-high.
- idata  in  `DATAW+1  flit from the crossbar output mux.
- ivalid  in  1  flit present on idata this cycle.
- ivch  in  `VCHW+1  VC of the incoming flit.
- odata  out  `DATAW+1  registered link data.
- ovalid  out  1  registered link valid.
- ovch  out  `VCHW+1  registered link VC.
- icredit  in  1  credit return pulse from the downstream router.
- icredit_vch  in  `VCHW+1  VC that the credit belongs to.
- ordy  out  NVC  bit v = 1 when the credit count of VC v is nonzero.
- ocnt  out  NVC*CNTW  concatenated credit counters, VC0 in the LSBs (for debug and statistics).
- err  out  2  sticky error flags: bit0 underflow, bit1 overflow.

## Operation
- Link register: each edge loads odata←idata, ovch←ivch and ovalid←ivalid. When ivalid=0, odata and ovch hold their previous value and ovalid←0.
- Credit counters: for each VC v:
  - dec_v = ivalid && ivch==v
  - inc_v = icredit && icredit_vch==v
  - next = cnt_v − dec_v + inc_v, computed at CNTW+1 bits, signed.
- Simultaneous dec_v and inc_v leave cnt_v unchanged and raise no error, including at cnt_v=0 and at cnt_v=CREDIT_INIT.
- Underflow: dec_v with no inc_v while cnt_v=0.
  - The flit is still forwarded.
  - cnt_v stays at 0.
  - err[0]←1.
- Overflow: inc_v with no dec_v while cnt_v=CREDIT_INIT.
  - cnt_v stays at CREDIT_INIT.
  - err[1]←1.
- Counters for different VCs update independently within the same cycle.
- ordy[v] = (cnt_v != 0), decoded combinationally from the counter register.
- err bits are cleared only by rst_.
- No state machine: the stage is a pure datapath register plus NVC saturating up/down counters.

## Timing
- Reset values (rst_=1 at an edge):
  - ovalid=0, odata=0, ovch=0.
  - Every cnt_v=CREDIT_INIT, so ordy is all ones.
  - err=0.
- Reset behaviour:
  - Reset takes priority over ivalid and icredit on the same edge.
  - A reset asserted in the middle of traffic discards the in-flight register contents.
- Latency:
  - Data: idata at edge t appears on odata after edge t (1 cycle).
  - Credit consumption: a flit accepted at edge t lowers cnt_v and ordy after edge t. The allocator therefore sees the reduced credit in the very next cycle, which permits back-to-back flits down to the last credit without overshoot.
  - Credit return: icredit at edge t is visible on ordy/ocnt after edge t.
- Throughput: one flit per cycle per port. No backpressure on idata; the allocator honours ordy.
- Wrap-around: counters never wrap and saturate at 0 and CREDIT_INIT.

## Test plan
- Reset, then idle: ovalid=0, ordy=2'b11, ocnt={4'd4,4'd4}, err=0.
- Four back-to-back flits on VC0 (data 0x11..0x14):
  - odata shows 0x11..0x14 on cycles t+1..t+4.
  - ordy[0] falls after the fourth edge; cnt1 stays 4.
- With cnt0=0, send a flit on VC0 and an icredit on VC0 in the same cycle: cnt0 stays 0 and err=0. Then send a flit alone: err[0]=1, flit still on the link, cnt0=0.
- At cnt1=4, icredit on VC1 with no traffic: err[1]=1, cnt1=4. A second credit leaves err[1]=1 (sticky).
- Simultaneous flit on VC1 and credit on VC0, starting from cnt0=2, cnt1=3: the next cycle gives cnt0=3, cnt1=2.
- Assert rst_ for one cycle during a VC0 stream with cnt0=1: the next cycle gives ovalid=0, cnt0=4, err=0, and flits resume normally.
